// File: rtl/poker_types.sv
// poker_types: shared poker widths, round states, cards and bot actions
package poker_types;
    localparam int MAX_STACK_W = 10;
    typedef enum logic [2:0] {PRE_DEAL, PRE_FLOP, FLOP, TURN, RIVER, SHOWDOWN} hand_state_t;
    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;
    typedef enum logic [1:0] {ACT_CHECK, ACT_CALL, ACT_BET, ACT_FOLD} bot_action_t;
endpackage

// File: rtl/poker_bot_player_lfsr.sv
// bot_lfsr: 8-bit Galois LFSR (mask 8'hB8) whose all-zero seed is forced to 8'h01
module bot_lfsr #(
    parameter logic [7:0] SEED = 8'h5A
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);
    localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;
    // free-running step; active-low reset reloads the seed
    always_ff @(posedge clk) begin
        if (!reset) q <= SEED_NZ;
        else q <= (q >> 1) ^ (q[0] ? 8'hB8 : 8'h00);
    end
endmodule

// File: rtl/poker_bot_player.sv
// poker_bot_player: automated seat that presses advance, thinks, then pulses one action button
module poker_bot_player
    import poker_types::*;
#(
    parameter int         BOT_SEAT       = 1,
    parameter int         THINK_CYCLES   = 8,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter bit         RANDOM_EN      = 1'b1,
    parameter logic [7:0] LFSR_SEED      = 8'h5A
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bot_enable,
    input  logic                   current_player,
    input  logic                   wait_screen,
    input  hand_state_t            curr_round_state,
    input  logic [MAX_STACK_W-1:0] call_size,
    input  logic [MAX_STACK_W-1:0] min_bet_or_raise,
    input  logic [MAX_STACK_W-1:0] player1_stack,
    input  logic [MAX_STACK_W-1:0] player2_stack,
    output logic                   advance_button,
    output logic                   check_or_call_button,
    output logic                   bet_or_raise_button,
    output logic                   fold_button,
    output logic [MAX_STACK_W-1:0] bet_input,
    output logic                   bot_busy,
    output logic                   bot_timeout
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > THINK_CYCLES) ? TIMEOUT_CYCLES : THINK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {IDLE, THINK, PRESS_ADV, WAIT_CLR, DECIDE, PRESS_ACT, WAIT_TURN} bot_state_t;

    bot_state_t             state, state_n;
    bot_action_t            act_q, act_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   timeout_n;
    logic [7:0]             r;
    logic [MAX_STACK_W-1:0] stack, bet_amt;
    logic [MAX_STACK_W:0]   raise_sum;
    logic                   showdown;
    logic                   unused_r;

    assign unused_r = ^r[7:3];

    bot_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (r)
    );

    // action policy evaluated on the current LFSR sample; only latched in DECIDE
    always_comb begin
        stack     = (BOT_SEAT == 0) ? player1_stack : player2_stack;
        showdown  = curr_round_state == SHOWDOWN;
        raise_sum = {1'b0, call_size} + {1'b0, min_bet_or_raise};
        bet_amt   = (min_bet_or_raise < stack) ? min_bet_or_raise : stack;
        if (!RANDOM_EN) act_n = (call_size == '0) ? ACT_CHECK : (call_size <= stack) ? ACT_CALL : ACT_FOLD;
        else if (call_size == '0) act_n = (r[1:0] == 2'd0 && stack >= min_bet_or_raise) ? ACT_BET : ACT_CHECK;
        else if (call_size <= stack) act_n = (r[2:0] == 3'd7 && raise_sum <= {1'b0, stack}) ? ACT_BET :
                                             (r[2:0] == 3'd0 && call_size > (stack >> 1)) ? ACT_FOLD : ACT_CALL;
        else act_n = r[0] ? ACT_CALL : ACT_FOLD;
    end

    // turn sequencing; one counter serves both the think delay and the advance timeout
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: if (bot_enable && current_player == 1'(BOT_SEAT) && wait_screen && !showdown) begin
                state_n = THINK;
                cnt_n   = CNT_W'(THINK_CYCLES - 1);
            end
            THINK: begin
                if (!bot_enable || showdown) state_n = IDLE;
                else if (cnt == '0) state_n = PRESS_ADV;
                else cnt_n = cnt - CNT_W'(1);
            end
            PRESS_ADV: begin
                state_n = WAIT_CLR;
                cnt_n   = '0;
            end
            WAIT_CLR: begin
                if (showdown) state_n = IDLE;
                else if (!wait_screen) state_n = DECIDE;
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
                else cnt_n = cnt + CNT_W'(1);
            end
            DECIDE:    state_n = PRESS_ACT;
            PRESS_ACT: state_n = WAIT_TURN;
            WAIT_TURN: if (wait_screen || showdown) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // state, decision and registered button pulses; bet_input holds from DECIDE until IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            act_q                <= ACT_CHECK;
            bet_input            <= '0;
            advance_button       <= 1'b0;
            check_or_call_button <= 1'b0;
            bet_or_raise_button  <= 1'b0;
            fold_button          <= 1'b0;
            bot_busy             <= 1'b0;
            bot_timeout          <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            advance_button       <= state == PRESS_ADV;
            check_or_call_button <= state == PRESS_ACT && (act_q == ACT_CHECK || act_q == ACT_CALL);
            bet_or_raise_button  <= state == PRESS_ACT && act_q == ACT_BET;
            fold_button          <= state == PRESS_ACT && act_q == ACT_FOLD;
            bot_busy             <= state_n != IDLE;
            bot_timeout          <= timeout_n;
            if (state == DECIDE) begin
                act_q     <= act_n;
                bet_input <= (act_n == ACT_BET) ? bet_amt : '0;
            end else if (state_n == IDLE) begin
                bet_input <= '0;
            end
        end
    end
endmodule

// File: tb/tb_poker_bot_player.sv
// tb_poker_bot_player: directed and randomised-turn checks for a deterministic and an LFSR-driven bot
module tb_poker_bot_player;
    import poker_types::*;
    localparam int W = MAX_STACK_W;
    localparam logic [2:0] A_CC = 3'b100, A_BR = 3'b010, A_FOLD = 3'b001;

    logic clk = 1'b0, reset = 1'b0, bot_enable = 1'b0, current_player = 1'b0, wait_screen = 1'b0;
    hand_state_t round_state = FLOP;
    logic [W-1:0] call_size = '0, min_bet = '0, p1_stack = '0, p2_stack = '0;
    logic d_adv, d_cc, d_br, d_fold, d_busy, d_to, r_adv, r_cc, r_br, r_fold, r_busy, r_to;
    logic [W-1:0] d_bet, r_bet;
    logic [7:0] m_lfsr, m_prev1, m_prev2;
    int n_pass = 0, n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    poker_bot_player #(.BOT_SEAT(1), .THINK_CYCLES(8), .TIMEOUT_CYCLES(16), .RANDOM_EN(1'b0), .LFSR_SEED(8'h5A)) dut_d (
        .clk(clk), .reset(reset), .bot_enable(bot_enable), .current_player(current_player),
        .wait_screen(wait_screen), .curr_round_state(round_state), .call_size(call_size),
        .min_bet_or_raise(min_bet), .player1_stack(p1_stack), .player2_stack(p2_stack),
        .advance_button(d_adv), .check_or_call_button(d_cc), .bet_or_raise_button(d_br),
        .fold_button(d_fold), .bet_input(d_bet), .bot_busy(d_busy), .bot_timeout(d_to));

    poker_bot_player #(.BOT_SEAT(1), .THINK_CYCLES(8), .TIMEOUT_CYCLES(16), .RANDOM_EN(1'b1), .LFSR_SEED(8'h5A)) dut_r (
        .clk(clk), .reset(reset), .bot_enable(bot_enable), .current_player(current_player),
        .wait_screen(wait_screen), .curr_round_state(round_state), .call_size(call_size),
        .min_bet_or_raise(min_bet), .player1_stack(p1_stack), .player2_stack(p2_stack),
        .advance_button(r_adv), .check_or_call_button(r_cc), .bet_or_raise_button(r_br),
        .fold_button(r_fold), .bet_input(r_bet), .bot_busy(r_busy), .bot_timeout(r_to));

    // reference LFSR with a two-deep history so the value seen in DECIDE is recoverable
    always @(posedge clk) begin
        m_prev2 <= m_prev1;
        m_prev1 <= m_lfsr;
        m_lfsr  <= !reset ? 8'h5A : m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    end

    function automatic logic [W+2:0] policy(input bit rnd, input logic [7:0] r,
                                            input logic [W-1:0] call, input logic [W-1:0] minb,
                                            input logic [W-1:0] stack);
        logic [2:0] a;
        logic [W-1:0] b;
        logic [W-1:0] amt;
        b = '0;
        amt = (minb < stack) ? minb : stack;
        if (call == 0) begin
            a = A_CC;
            if (rnd && r[1:0] == 2'd0 && stack >= minb) begin a = A_BR; b = amt; end
        end else if (call <= stack) begin
            a = A_CC;
            if (rnd && r[2:0] == 3'd7 && int'(call) + int'(minb) <= int'(stack)) begin a = A_BR; b = amt; end
            else if (rnd && r[2:0] == 3'd0 && 2 * int'(call) > int'(stack)) a = A_FOLD;
        end else begin
            a = (rnd && r[0]) ? A_CC : A_FOLD;
        end
        return {a, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic turn(input string tag, input logic [2:0] exp_d, input logic [W-1:0] exp_db);
        int k;
        logic [W+2:0] mr;
        current_player = 1'b1;
        wait_screen = 1'b1;
        bot_enable = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!d_adv && k < 20);
        chk({tag, ".adv_latency"}, k, 10);
        chk({tag, ".r_adv"}, r_adv, 1);
        @(negedge clk);
        chk({tag, ".adv_once"}, {d_adv, r_adv}, 0);
        wait_screen = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!(d_cc | d_br | d_fold) && k < 10);
        chk({tag, ".act_latency"}, k, 3);
        mr = policy(1'b1, m_prev2, call_size, min_bet, p2_stack);
        chk({tag, ".d_act"}, {d_cc, d_br, d_fold}, exp_d);
        chk({tag, ".d_bet"}, d_bet, exp_db);
        chk({tag, ".r_act"}, {r_cc, r_br, r_fold}, mr[W+2:W]);
        chk({tag, ".r_bet"}, r_bet, mr[W-1:0]);
        chk({tag, ".r_bet_le_stack"}, r_bet <= p2_stack, 1);
        @(negedge clk);
        chk({tag, ".act_once"}, {d_cc, d_br, d_fold, r_cc, r_br, r_fold}, 0);
        wait_screen = 1'b1;
        current_player = 1'b0;
        @(negedge clk);
        chk({tag, ".idle"}, {d_busy, r_busy, d_bet, r_bet}, 0);
    endtask

    task automatic quiet(input string tag, input int n);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            acc |= d_adv | d_cc | d_br | d_fold | d_busy | d_to | r_adv | r_cc | r_br | r_fold | r_busy | r_to;
        end
        chk(tag, acc, 0);
    endtask

    initial begin
        int k;
        logic [W+2:0] pd;
        repeat (3) @(negedge clk);
        chk("reset.d_flags", {d_adv, d_cc, d_br, d_fold, d_busy, d_to}, 0);
        chk("reset.r_flags", {r_adv, r_cc, r_br, r_fold, r_busy, r_to}, 0);
        chk("reset.bets", {d_bet, r_bet}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        call_size = 10'd0;   min_bet = 10'd20; p2_stack = 10'd500; p1_stack = 10'd7;
        turn("check", A_CC, 10'd0);
        call_size = 10'd200; min_bet = 10'd20; p2_stack = 10'd150;
        turn("fold_short", A_FOLD, 10'd0);
        call_size = 10'd100; min_bet = 10'd40; p2_stack = 10'd150;
        turn("call", A_CC, 10'd0);
        call_size = 10'd150; min_bet = 10'd40; p2_stack = 10'd150;
        turn("call_all_in_edge", A_CC, 10'd0);

        current_player = 1'b1; wait_screen = 1'b1; bot_enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid.busy_before", d_busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid.cleared", {d_busy, r_busy, d_bet, r_bet}, 0);
        quiet("rst_mid.held", 12);
        current_player = 1'b0;
        reset = 1'b1;
        quiet("rst_mid.after", 5);

        current_player = 1'b1; wait_screen = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!d_adv && k < 20);
        chk("timeout.adv_latency", k, 10);
        k = 0;
        do begin @(negedge clk); k++; end while (!d_to && k < 40);
        chk("timeout.latency", k, 16);
        chk("timeout.r_pulse", r_to, 1);
        chk("timeout.busy", {d_busy, r_busy}, 0);
        current_player = 1'b0;
        @(negedge clk);
        chk("timeout.once", {d_to, r_to, d_busy, r_busy}, 0);

        current_player = 1'b0; wait_screen = 1'b1; bot_enable = 1'b1; round_state = FLOP;
        quiet("idle.other_seat", 70);
        current_player = 1'b1; round_state = SHOWDOWN;
        quiet("idle.showdown", 70);
        round_state = RIVER; bot_enable = 1'b0;
        quiet("idle.disabled", 70);

        bot_enable = 1'b1;
        repeat (3) @(negedge clk);
        bot_enable = 1'b0;
        quiet("think.enable_drop", 30);

        bot_enable = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!d_adv && k < 20);
        chk("wait_clr.adv_latency", k, 10);
        round_state = SHOWDOWN;
        quiet("wait_clr.showdown", 30);
        round_state = FLOP;
        current_player = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 500; t++) begin
            p2_stack  = W'($urandom_range(0, 600));
            p1_stack  = W'($urandom_range(0, 600));
            call_size = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, 700));
            min_bet   = W'($urandom_range(0, 400));
            pd = policy(1'b0, 8'h00, call_size, min_bet, p2_stack);
            turn("rand", pd[W+2:W], pd[W-1:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/poker_bot_player.md
Name: poker_bot_player

Overview:
- Automated opponent that drives the `game_fsm` player-input interface (`advance_button`, action buttons, `bet_input`) for one seat.
- It watches the round-level outputs and, when its seat is up, dismisses the wait screen, thinks for a fixed delay, picks an action, and pulses the matching button.
- It sits beside the human button conditioner at top level. Its outputs are ORed with the human's button pulses. The bot only acts on its own turn, so the two sources never overlap.

Parameters:
- BOT_SEAT, 1, value of `current_player` that this bot controls.
- THINK_CYCLES, 8, idle cycles between seeing its turn and pressing advance (min 1).
- TIMEOUT_CYCLES, 1024, max cycles to wait for `wait_screen` to drop after advance.
- RANDOM_EN, 1, 1 = LFSR-driven policy; 0 = deterministic policy.
- LFSR_SEED, 8'h5A, 8-bit LFSR seed; a seed of 0 is replaced by 8'h01.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- bot_enable  in  1  bot may act when 1
- current_player  in  1  seat to act
- wait_screen  in  1  game is showing the hand-over screen
- curr_round_state  in  hand_state_t  round state; only `showdown` is decoded
- call_size  in  MAX_STACK_W  amount needed to call
- min_bet_or_raise  in  MAX_STACK_W  minimum bet/raise size
- player1_stack  in  MAX_STACK_W  seat 0 stack
- player2_stack  in  MAX_STACK_W  seat 1 stack
- advance_button  out  1  one-cycle pulse
- check_or_call_button  out  1  one-cycle pulse
- bet_or_raise_button  out  1  one-cycle pulse
- fold_button  out  1  one-cycle pulse
- bet_input  out  MAX_STACK_W  bet amount, held from DECIDE until IDLE
- bot_busy  out  1  FSM not in IDLE
- bot_timeout  out  1  one-cycle pulse on advance timeout

Behaviour:
- **Reset** (`reset`==0 at posedge):
  - state = IDLE; all buttons, `bot_timeout` and `bot_busy` = 0; `bet_input` = 0; counters = 0; LFSR = seed.
  - A reset mid-sequence aborts with no further pulses.
- **Registers:** all outputs are registered. Each button is high for exactly one cycle per press, and at most one button is high in any cycle.
- **Own stack:** player1_stack if BOT_SEAT==0, else player2_stack.
- **LFSR:** 8-bit Galois, mask 8'hB8, steps every cycle out of reset. The DECIDE state samples r = LFSR.
- **IDLE:** go to THINK when all of the following hold: `bot_enable`, `current_player`==BOT_SEAT, `wait_screen`, `curr_round_state`!=showdown. The think counter loads THINK_CYCLES-1.
- **THINK:**
  - Counter decrements each cycle; at 0 go to PRESS_ADV.
  - If `bot_enable` drops, return to IDLE with no pulse.
- **PRESS_ADV:** `advance_button`=1 for one cycle, then go to WAIT_CLR. The timeout counter clears.
- **WAIT_CLR:**
  - When `wait_screen`==0, go to DECIDE.
  - If the counter reaches TIMEOUT_CYCLES-1, pulse `bot_timeout` and go to IDLE.
- **DECIDE** (one cycle): computes the action and registers `bet_input`.
  - RANDOM_EN=0:
    - call_size==0 → check.
    - call_size<=stack → call.
    - Otherwise → fold.
  - RANDOM_EN=1, call_size==0:
    - r[1:0]==0 and stack>=min_bet → bet.
    - Otherwise → check.
  - RANDOM_EN=1, 0<call_size<=stack:
    - r[2:0]==7 and stack>=call_size+min_bet → raise.
    - r[2:0]==0 and call_size>(stack>>1) → fold.
    - Otherwise → call.
  - RANDOM_EN=1, call_size>stack: r[0] → call (all-in); otherwise fold.
  - Bet/raise amount: `bet_input` = min(min_bet_or_raise, stack).
  - Check/call/fold: `bet_input` = 0.
  - The sum call_size+min_bet uses MAX_STACK_W+1 bits, so no wrap.
- **PRESS_ACT:** pulse the selected button for one cycle, then go to WAIT_TURN.
- **WAIT_TURN:** go to IDLE once `wait_screen`==1 or `curr_round_state`==showdown. This stops the bot re-triggering on a stale wait screen.
- **Showdown:** if showdown is seen in THINK or WAIT_CLR, go to IDLE with no further pulse.

Decomposition:
- Package `poker_types`: existing MAX_STACK_W, hand_state_t and card_t. Add a new `bot_action_t` enum {ACT_CHECK, ACT_CALL, ACT_BET, ACT_FOLD}.
- One sub-module, `bot_lfsr` (8-bit Galois LFSR with seed parameter and zero-seed guard).
- The FSM and the decision logic stay in `poker_bot_player`.

Test Plan:
1. Advance then check: RANDOM_EN=0, THINK_CYCLES=8, BOT_SEAT=1; current_player=1, wait_screen=1, call_size=0.
   - `advance_button` pulses exactly 9 cycles after entry to THINK.
   - Dropping `wait_screen` → `check_or_call_button` pulses 2 cycles later, with `bet_input`=0.
2. Fold on short stack: RANDOM_EN=0; call_size=200, player2_stack=150 → `fold_button` is the only action pulse.
3. Reset mid-sequence: reset=0 during THINK → no pulses; `bot_busy`=0 on the next cycle; `bet_input`=0.
4. Timeout: keep `wait_screen`=1 after advance with TIMEOUT_CYCLES=16 → one `bot_timeout` pulse 16 cycles after advance, then return to IDLE.
5. Not the bot's turn: current_player=0, or showdown asserted, or `bot_enable`=0 → no button ever pulses over 200 cycles.
6. Randomised policy: RANDOM_EN=1, seed 8'h5A, 500 turns against a scoreboard LFSR model.
   - Every action and `bet_input` matches the model.
   - `bet_input`<=stack always.
   - Exactly one action pulse per advance pulse.
